mmio_bus_initiator: RTL

FPro-bus initiator that turns a valid/ready command stream into single-cycle MMIO read/write transactions. It drives `mmio_cs/mmio_wr/mmio_rd/mmio_addr/mmio_wr_data` into the MMIO subsystem and returns read data on a valid/ready response port. Typical uses are a debug/UART bridge, a hardware sequencer, or a test harness standing in for the processor. Commands are buffered in a small FIFO and issued strictly in order.

---
 rtl/mmio_bus_initiator.sv | 119 +++++++++++
 1 files changed

// File: rtl/mmio_bus_initiator.sv
// Command-stream to MMIO bus initiator: buffers {wr, addr, wdata} commands in a
// small FIFO and issues them in order as single-cycle bus strobes.
module mmio_bus_initiator #(
   parameter int FIFO_DEPTH_BIT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_wr,
   input  logic [20:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        mmio_cs,
   output logic        mmio_wr,
   output logic        mmio_rd,
   output logic [20:0] mmio_addr,
   output logic [31:0] mmio_wr_data,
   input  logic [31:0] mmio_rd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        busy
);

   // state    | meaning
   // BUS_IDLE | no strobe on the bus this cycle
   // BUS_WR   | write strobe (cs, wr) driven this cycle
   // BUS_RD   | read strobe (cs, rd) driven; rd_data captured at the closing edge
   typedef enum logic [1:0] {BUS_IDLE, BUS_WR, BUS_RD} bus_state_t;

   localparam int DEPTH = 1 << FIFO_DEPTH_BIT;
   localparam int ENTRY_W = 54;
   localparam logic [FIFO_DEPTH_BIT:0] PTR_ONE = 1;

   logic [ENTRY_W-1:0]    fifo_mem_q [DEPTH];
   logic [FIFO_DEPTH_BIT:0] wptr_q, wptr_d, rptr_q, rptr_d;
   bus_state_t            state_q, state_d;
   logic [20:0]           addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  rsp_valid_q, rsp_valid_d;

   logic                  empty, full, push, issue;
   logic                  head_wr;
   logic [20:0]           head_addr;
   logic [31:0]           head_wdata;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[FIFO_DEPTH_BIT] != rptr_q[FIFO_DEPTH_BIT]) &&
                  (wptr_q[FIFO_DEPTH_BIT-1:0] == rptr_q[FIFO_DEPTH_BIT-1:0]);
   assign {head_wr, head_addr, head_wdata} = fifo_mem_q[rptr_q[FIFO_DEPTH_BIT-1:0]];

   assign push = cmd_valid && !full;
   // A read waits until the response slot is free and no read is on the bus,
   // so at most one read is ever outstanding.
   assign issue = !empty && (head_wr || (!rsp_valid_q && state_q != BUS_RD));

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      state_d     = BUS_IDLE;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      rsp_valid_d = rsp_valid_q;
      if (push) begin
         wptr_d = wptr_q + PTR_ONE;
      end
      if (issue) begin
         rptr_d  = rptr_q + PTR_ONE;
         state_d = head_wr ? BUS_WR : BUS_RD;
         addr_d  = head_addr;
         wdata_d = head_wdata;
      end
      if (state_q == BUS_RD) begin
         rsp_valid_d = 1'b1;
         rdata_d     = mmio_rd_data;
      end else if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wptr_q[FIFO_DEPTH_BIT-1:0]] <= {cmd_wr, cmd_addr, cmd_wdata};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         state_q     <= BUS_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign cmd_ready    = !full;
   assign mmio_cs      = (state_q != BUS_IDLE);
   assign mmio_wr      = (state_q == BUS_WR);
   assign mmio_rd      = (state_q == BUS_RD);
   assign mmio_addr    = addr_q;
   assign mmio_wr_data = wdata_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rdata_q;
   assign busy         = !empty || mmio_cs || rsp_valid_q;

endmodule
